// File: rtl/class_argmax_if.sv
// -----------------------------------------------------------------------------
// class_argmax_if
// Purpose : Groups the score stream and the result stream of class_argmax into
//           one bundle so the design and its environment connect through a
//           single port.
// Signals : in_valid/in_ready/in_data/in_last  - score stream, one class per beat
//           out_valid/out_ready                 - result handshake
//           out_digit/out_score/out_error       - winning index, winning score,
//                                                 beat-count error flag
// Modports: slave  - the argmax block (consumes scores, produces the result)
//           master - the environment (produces scores, consumes the result)
// -----------------------------------------------------------------------------
interface class_argmax_if #(
  parameter int SCORE_W = 16
) ();

  logic               in_valid;
  logic               in_ready;
  logic [SCORE_W-1:0] in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         out_digit;
  logic [SCORE_W-1:0] out_score;
  logic               out_error;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_digit, out_score, out_error
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_digit, out_score, out_error
  );

endinterface

// File: rtl/class_argmax.sv
// -----------------------------------------------------------------------------
// class_argmax
// Purpose : Receives NUM_CLASSES signed class scores per image and reports the
//           index and value of the largest one. Ties keep the lowest index.
//           A wrong beat count at in_last raises out_error; beats beyond
//           NUM_CLASSES are accepted but discarded.
// Ports   : Clk      - single clock, rising edge
//           Reset_n  - asynchronous active-low reset
//           bus      - class_argmax_if.slave (score stream in, result out)
// Result  : out_valid rises the cycle after the last accepted beat and holds,
//           with all result fields stable, until out_ready is seen.
// -----------------------------------------------------------------------------
module class_argmax #(
  parameter int SCORE_W     = 16,
  parameter int NUM_CLASSES = 10
) (
  input  logic           Clk,
  input  logic           Reset_n,
  class_argmax_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] NC = 4'(NUM_CLASSES);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic signed [SCORE_W-1:0] r_best_score;
  logic signed [SCORE_W-1:0] w_best_score_nxt;
  logic [3:0]                r_best_idx;
  logic [3:0]                w_best_idx_nxt;
  logic [3:0]                r_count;
  logic [3:0]                w_count_nxt;
  logic                      r_err;
  logic                      w_err_nxt;
  logic                      r_in_ready;
  logic                      r_out_valid;

  logic                      w_xfer;
  logic signed [SCORE_W-1:0] w_data;
  logic [3:0]                w_count_inc;

  assign w_data      = $signed(bus.in_data);
  // in_ready is registered from the next state, so it always reflects the
  // state the edge will be sampled in.
  assign w_xfer      = bus.in_valid & r_in_ready;
  assign w_count_inc = r_count + 4'd1;

  // Next-state and datapath update for the IDLE/ACCUM/DONE sequence.
  always_comb begin
    w_state_nxt      = r_state;
    w_best_score_nxt = r_best_score;
    w_best_idx_nxt   = r_best_idx;
    w_count_nxt      = r_count;
    w_err_nxt        = r_err;

    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          // First beat of a new image seeds the best with index 0.
          w_best_score_nxt = w_data;
          w_best_idx_nxt   = 4'd0;
          w_count_nxt      = 4'd1;
          if (bus.in_last) begin
            w_err_nxt   = (NC != 4'd1);
            w_state_nxt = DONE;
          end else begin
            w_err_nxt   = 1'b0;
            w_state_nxt = ACCUM;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end

      ACCUM: begin
        if (w_xfer) begin
          if (r_count >= NC) begin
            // Overflow beat: flag it, drop the data, count stays saturated.
            w_err_nxt = 1'b1;
          end else begin
            // Strict compare keeps the earlier index on a tie.
            if (w_data > r_best_score) begin
              w_best_score_nxt = w_data;
              w_best_idx_nxt   = r_count;
            end else begin
              w_best_score_nxt = r_best_score;
            end
            w_count_nxt = w_count_inc;
            if (bus.in_last && (w_count_inc != NC)) begin
              w_err_nxt = 1'b1;
            end else begin
              w_err_nxt = r_err;
            end
          end
          if (bus.in_last) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = ACCUM;
          end
        end else begin
          w_state_nxt = ACCUM;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= IDLE;
      r_best_score <= '0;
      r_best_idx   <= 4'd0;
      r_count      <= 4'd0;
      r_err        <= 1'b0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_best_score <= w_best_score_nxt;
      r_best_idx   <= w_best_idx_nxt;
      r_count      <= w_count_nxt;
      r_err        <= w_err_nxt;
      r_in_ready   <= (w_state_nxt != DONE);
      r_out_valid  <= (w_state_nxt == DONE);
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_digit = r_best_idx;
  assign bus.out_score = r_best_score;
  assign bus.out_error = r_err;

endmodule
